// File: rtl/cache_memory_sa_if.sv
// Request/response bundle between the cache controller (master) and the
// set-associative tag/data store (slave).
interface cache_memory_sa_if #(
  parameter int TAG_WIDTH    = 24,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 2,
  parameter int WORD_WIDTH   = 32,
  parameter int WAYS         = 2
);
  localparam int BLOCK_SIZE = (2**OFFSET_WIDTH) * WORD_WIDTH;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_WIDTH-1:0]    tag;
  logic [INDEX_WIDTH-1:0]  index;
  logic [OFFSET_WIDTH-1:0] blk_offset;
  logic                    req_type;
  logic                    read_en_cache;
  logic                    write_en_cache;
  logic                    refill;
  logic [BLOCK_SIZE-1:0]   data_in_mem;
  logic [WORD_WIDTH-1:0]   data_in;

  logic [BLOCK_SIZE-1:0]   dirty_block_out;
  logic [TAG_WIDTH-1:0]    evict_tag;
  logic [WAY_W-1:0]        victim_way;
  logic                    hit;
  logic [WORD_WIDTH-1:0]   data_out;
  logic                    dirty_bit;

  modport master (
    output tag, index, blk_offset, req_type, read_en_cache, write_en_cache,
           refill, data_in_mem, data_in,
    input  dirty_block_out, evict_tag, victim_way, hit, data_out, dirty_bit
  );

  modport slave (
    input  tag, index, blk_offset, req_type, read_en_cache, write_en_cache,
           refill, data_in_mem, data_in,
    output dirty_block_out, evict_tag, victim_way, hit, data_out, dirty_bit
  );
endinterface

// File: rtl/cache_memory_sa.sv
// N-way set-associative cache tag/data store with true-LRU replacement,
// registered lookups, dirty-victim reporting and write-allocate refill.
module cache_memory_sa #(
  parameter int TAG_WIDTH    = 24,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 2,
  parameter int WORD_WIDTH   = 32,
  parameter int WAYS         = 2
) (
  input  logic              clk,
  input  logic              rst,
  cache_memory_sa_if.slave  bus
);
  localparam int SETS       = 2**INDEX_WIDTH;
  localparam int WORDS      = 2**OFFSET_WIDTH;
  localparam int BLOCK_SIZE = WORDS * WORD_WIDTH;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [BLOCK_SIZE-1:0] block_t;
  typedef logic [WAY_W-1:0]      way_t;

  tag_t            tag_store   [WAYS][SETS];
  block_t          data_store  [WAYS][SETS];
  logic [SETS-1:0] valid_store [WAYS];
  logic [SETS-1:0] dirty_store [WAYS];
  way_t            age_store   [SETS][WAYS];

  logic            lookup;
  logic            do_refill;
  logic [WAYS-1:0] way_valid;
  logic [WAYS-1:0] match;
  logic            any_hit;
  logic            any_free;
  way_t            hit_way;
  way_t            free_way;
  way_t            lru_way;
  way_t            pick_way;
  way_t            touch_way;
  way_t            next_age [WAYS];
  block_t          hit_block;
  block_t          victim_block;
  tag_t            victim_tag;
  logic            victim_dirty;
  block_t          refill_block;
  word_t           hit_word;
  word_t           refill_word;

  logic            hit_q;
  word_t           data_out_q;
  logic            dirty_bit_q;
  way_t            victim_way_q;
  tag_t            evict_tag_q;
  block_t          dirty_block_q;

  assign do_refill = bus.refill & bus.write_en_cache;
  assign lookup    = ~bus.refill & (bus.read_en_cache | bus.write_en_cache);

  always_comb begin
    way_valid = '0;
    match     = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_valid[w] = valid_store[w][bus.index];
      match[w]     = way_valid[w] && (tag_store[w][bus.index] == bus.tag);
    end
  end

  // Descending scan leaves the lowest-index hit/free way as the winner.
  always_comb begin
    any_hit  = 1'b0;
    any_free = 1'b0;
    hit_way  = '0;
    free_way = '0;
    lru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        any_hit = 1'b1;
        hit_way = way_t'(w);
      end
      if (!way_valid[w]) begin
        any_free = 1'b1;
        free_way = way_t'(w);
      end
      if (age_store[bus.index][w] == way_t'(WAYS - 1)) begin
        lru_way = way_t'(w);
      end
    end
    pick_way = any_free ? free_way : lru_way;
  end

  always_comb begin
    hit_block    = data_store[hit_way][bus.index];
    hit_word     = hit_block[bus.blk_offset*WORD_WIDTH +: WORD_WIDTH];
    victim_block = data_store[pick_way][bus.index];
    victim_tag   = tag_store[pick_way][bus.index];
    victim_dirty = valid_store[pick_way][bus.index] & dirty_store[pick_way][bus.index];
  end

  // Write-allocate: the pending store word overrides the memory copy.
  always_comb begin
    refill_block = bus.data_in_mem;
    if (bus.req_type) begin
      refill_block[bus.blk_offset*WORD_WIDTH +: WORD_WIDTH] = bus.data_in;
    end
    refill_word = refill_block[bus.blk_offset*WORD_WIDTH +: WORD_WIDTH];
  end

  // Ages stay a permutation: only ways younger than the touched one age by one.
  always_comb begin
    touch_way = do_refill ? victim_way_q : hit_way;
    for (int w = 0; w < WAYS; w++) begin
      next_age[w] = age_store[bus.index][w];
      if (way_t'(w) == touch_way) begin
        next_age[w] = '0;
      end else if (age_store[bus.index][w] < age_store[bus.index][touch_way]) begin
        next_age[w] = age_store[bus.index][w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_store[w] <= '0;
        dirty_store[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_store[w][s]  <= '0;
          data_store[w][s] <= '0;
          age_store[s][w]  <= way_t'(w);
        end
      end
    end else if (do_refill) begin
      data_store[victim_way_q][bus.index]  <= refill_block;
      tag_store[victim_way_q][bus.index]   <= bus.tag;
      valid_store[victim_way_q][bus.index] <= 1'b1;
      dirty_store[victim_way_q][bus.index] <= bus.req_type;
      for (int w = 0; w < WAYS; w++) begin
        age_store[bus.index][w] <= next_age[w];
      end
    end else if (lookup && any_hit) begin
      if (bus.req_type) begin
        data_store[hit_way][bus.index][bus.blk_offset*WORD_WIDTH +: WORD_WIDTH] <= bus.data_in;
        dirty_store[hit_way][bus.index] <= 1'b1;
      end
      for (int w = 0; w < WAYS; w++) begin
        age_store[bus.index][w] <= next_age[w];
      end
    end
  end

  // Victim information is only refreshed on a miss so the refill that follows
  // targets the way chosen by that miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q         <= 1'b0;
      data_out_q    <= '0;
      dirty_bit_q   <= 1'b0;
      victim_way_q  <= '0;
      evict_tag_q   <= '0;
      dirty_block_q <= '0;
    end else if (do_refill) begin
      hit_q       <= 1'b1;
      dirty_bit_q <= 1'b0;
      data_out_q  <= refill_word;
    end else if (lookup) begin
      if (any_hit) begin
        hit_q       <= 1'b1;
        dirty_bit_q <= 1'b0;
        if (!bus.req_type) begin
          data_out_q <= hit_word;
        end
      end else begin
        hit_q         <= 1'b0;
        data_out_q    <= '0;
        victim_way_q  <= pick_way;
        dirty_bit_q   <= victim_dirty;
        evict_tag_q   <= victim_tag;
        dirty_block_q <= victim_block;
      end
    end
  end

  assign bus.hit             = hit_q;
  assign bus.data_out        = data_out_q;
  assign bus.dirty_bit       = dirty_bit_q;
  assign bus.victim_way      = victim_way_q;
  assign bus.evict_tag       = evict_tag_q;
  assign bus.dirty_block_out = dirty_block_q;
endmodule

// File: tb/tb_cache_memory_sa.sv
// Directed plus constrained-random bench for cache_memory_sa (default 2-way
// configuration) with a behavioural model feeding an expected-result queue.
module tb_cache_memory_sa;
  logic clk;
  logic rst;

  cache_memory_sa_if bus ();

  cache_memory_sa dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         hit;
    logic [31:0]  dout;
    logic         dbit;
    logic         vway;
    logic [23:0]  etag;
    logic [127:0] dblk;
    bit           chk_dbit;
    bit           chk_evict;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0]  m_tag   [2][64];
  logic [127:0] m_data  [2][64];
  bit           m_valid [2][64];
  bit           m_dirty [2][64];
  int           m_age   [64][2];
  logic         m_hit;
  logic [31:0]  m_dout;
  logic         m_dbit;
  logic         m_vway;
  logic [23:0]  m_etag;
  logic [127:0] m_dblk;
  bit           m_chk_dbit;
  bit           m_chk_evict;

  task automatic check_field(string name, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic m_touch(int s, int a);
    int k;
    k = m_age[s][a];
    for (int w = 0; w < 2; w++) begin
      if (w == a) m_age[s][w] = 0;
      else if (m_age[s][w] < k) m_age[s][w] = m_age[s][w] + 1;
    end
  endtask

  // Reference behaviour for one clock edge given the inputs currently driven.
  task automatic model_apply(string name);
    exp_t         e;
    int           s;
    int           nm;
    int           hw;
    int           v;
    logic [127:0] blk;
    s = int'(bus.index);
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 64; i++) begin
          m_valid[w][i] = 0; m_dirty[w][i] = 0; m_data[w][i] = '0; m_tag[w][i] = '0;
          m_age[i][w] = w;
        end
      m_hit = 0; m_dout = '0; m_dbit = 0; m_vway = 0; m_etag = '0; m_dblk = '0;
      m_chk_dbit = 1; m_chk_evict = 1;
    end else if (bus.refill && bus.write_en_cache) begin
      blk = bus.data_in_mem;
      if (bus.req_type) blk[bus.blk_offset*32 +: 32] = bus.data_in;
      v = int'(m_vway);
      m_data[v][s] = blk; m_tag[v][s] = bus.tag; m_valid[v][s] = 1; m_dirty[v][s] = bus.req_type;
      m_touch(s, v);
      m_hit = 1; m_dbit = 0; m_dout = blk[bus.blk_offset*32 +: 32];
      m_chk_dbit = 1; m_chk_evict = 0;
    end else if (!bus.refill && (bus.read_en_cache || bus.write_en_cache)) begin
      nm = 0; hw = 0;
      for (int w = 0; w < 2; w++)
        if (m_valid[w][s] && m_tag[w][s] == bus.tag) begin nm++; hw = w; end
      check_field({name, "_unique_match"}, 128'(nm <= 1), 128'(1));
      if (nm > 0) begin
        m_hit = 1; m_chk_evict = 0;
        if (bus.req_type) begin
          m_data[hw][s][bus.blk_offset*32 +: 32] = bus.data_in;
          m_dirty[hw][s] = 1; m_chk_dbit = 0;
        end else begin
          m_dout = m_data[hw][s][bus.blk_offset*32 +: 32];
          m_dbit = 0; m_chk_dbit = 1;
        end
        m_touch(s, hw);
      end else begin
        v = -1;
        for (int w = 1; w >= 0; w--) if (!m_valid[w][s]) v = w;
        if (v < 0) for (int w = 0; w < 2; w++) if (m_age[s][w] == 1) v = w;
        m_hit = 0; m_dout = '0; m_vway = v[0];
        m_dbit = m_valid[v][s] && m_dirty[v][s];
        m_etag = m_tag[v][s]; m_dblk = m_data[v][s];
        m_chk_dbit = 1; m_chk_evict = 1;
      end
    end
    e.name = name; e.hit = m_hit; e.dout = m_dout; e.dbit = m_dbit; e.vway = m_vway;
    e.etag = m_etag; e.dblk = m_dblk; e.chk_dbit = m_chk_dbit; e.chk_evict = m_chk_evict;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      check_field("scoreboard_empty", 128'(1), 128'(0));
      return;
    end
    e = sb.pop_front();
    check_field({e.name, "_hit"}, 128'(bus.hit), 128'(e.hit));
    check_field({e.name, "_data_out"}, 128'(bus.data_out), 128'(e.dout));
    check_field({e.name, "_victim_way"}, 128'(bus.victim_way), 128'(e.vway));
    if (e.chk_dbit) check_field({e.name, "_dirty_bit"}, 128'(bus.dirty_bit), 128'(e.dbit));
    if (e.chk_evict) begin
      check_field({e.name, "_evict_tag"}, 128'(bus.evict_tag), 128'(e.etag));
      check_field({e.name, "_dirty_block"}, bus.dirty_block_out, e.dblk);
    end
  endtask

  task automatic apply_stimulus(string name, bit r, bit rf, bit re, bit we, bit rt,
                                logic [23:0] t, logic [5:0] idx, logic [1:0] off,
                                logic [31:0] din, logic [127:0] dmem);
    rst = r; bus.refill = rf; bus.read_en_cache = re; bus.write_en_cache = we;
    bus.req_type = rt; bus.tag = t; bus.index = idx; bus.blk_offset = off;
    bus.data_in = din; bus.data_in_mem = dmem;
    model_apply(name);
    @(posedge clk);
    #1;
    rst = 0; bus.refill = 0; bus.read_en_cache = 0; bus.write_en_cache = 0;
    check_output();
  endtask

  task automatic do_reset(string name);
    apply_stimulus(name, 1, 0, 0, 0, 0, '0, '0, '0, '0, '0);
  endtask
  task automatic do_read(string name, logic [23:0] t, logic [5:0] idx, logic [1:0] off);
    apply_stimulus(name, 0, 0, 1, 0, 0, t, idx, off, '0, '0);
  endtask
  task automatic do_write(string name, logic [23:0] t, logic [5:0] idx, logic [1:0] off, logic [31:0] d);
    apply_stimulus(name, 0, 0, 0, 1, 1, t, idx, off, d, '0);
  endtask
  task automatic do_refill(string name, logic [23:0] t, logic [5:0] idx, logic [1:0] off,
                           bit rt, logic [31:0] d, logic [127:0] mem);
    apply_stimulus(name, 0, 1, 0, 1, rt, t, idx, off, d, mem);
  endtask

  localparam logic [127:0] MEM_A = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] MEM_B = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
  localparam logic [127:0] MEM_C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] MEM_D = 128'hD000000D_D111111D_D222222D_D333333D;

  initial begin : stimulus
    logic [23:0]  tags [4];
    bit           last_miss;
    logic [23:0]  l_tag;
    logic [5:0]   l_idx;
    logic [1:0]   l_off;
    bit           l_rt;
    logic [31:0]  l_din;
    bit           re;
    bit           we;
    rst = 0; bus.refill = 0; bus.read_en_cache = 0; bus.write_en_cache = 0;
    bus.req_type = 0; bus.tag = '0; bus.index = '0; bus.blk_offset = '0;
    bus.data_in = '0; bus.data_in_mem = '0;
    @(posedge clk); #1;
    $display("[TB] directed phase");

    do_reset("reset");
    check_field("plan_reset_hit", 128'(bus.hit), 128'(0));
    check_field("plan_reset_dout", 128'(bus.data_out), 128'(0));
    do_read("first_miss", 24'hABCDE0, 6'd0, 2'd0);
    check_field("plan_first_victim", 128'(bus.victim_way), 128'(0));
    do_refill("refill_a", 24'hABCDE0, 6'd0, 2'd3, 0, '0, MEM_A);
    do_read("read_off3", 24'hABCDE0, 6'd0, 2'd3);
    check_field("plan_read_off3", 128'(bus.data_out), 128'h11112222);
    do_write("write_hit", 24'hABCDE0, 6'd0, 2'd0, 32'hCAFEBABE);
    do_read("read_back", 24'hABCDE0, 6'd0, 2'd0);
    check_field("plan_read_back", 128'(bus.data_out), 128'hCAFEBABE);
    do_read("miss_abc", 24'h000ABC, 6'd0, 2'd1);
    check_field("plan_invalid_victim", 128'(bus.victim_way), 128'(1));
    do_refill("refill_abc", 24'h000ABC, 6'd0, 2'd1, 0, '0, MEM_B);
    do_read("touch_a", 24'hABCDE0, 6'd0, 2'd2);
    do_read("miss_3c", 24'h3C3C3C, 6'd0, 2'd0);
    check_field("plan_lru_etag", 128'(bus.evict_tag), 128'h000ABC);
    do_refill("refill_3c", 24'h3C3C3C, 6'd0, 2'd0, 0, '0, MEM_C);
    do_read("miss_111", 24'h111111, 6'd0, 2'd0);
    check_field("plan_dirty_victim", 128'(bus.dirty_bit), 128'(1));
    check_field("plan_dirty_word0", 128'(bus.dirty_block_out[31:0]), 128'hCAFEBABE);

    do_write("wmiss_idx4", 24'h1A2B3C, 6'd4, 2'd2, 32'h4AFEBABE);
    do_refill("walloc", 24'h1A2B3C, 6'd4, 2'd2, 1, 32'h4AFEBABE, MEM_D);
    check_field("plan_walloc_word", 128'(bus.data_out), 128'h4AFEBABE);
    do_read("walloc_hit", 24'h1A2B3C, 6'd4, 2'd2);
    do_read("walloc_mem", 24'h1A2B3C, 6'd4, 2'd1);
    do_read("fill_way1", 24'h000002, 6'd4, 2'd0);
    do_refill("refill_way1", 24'h000002, 6'd4, 2'd0, 0, '0, MEM_B);
    do_read("evict_walloc", 24'h000003, 6'd4, 2'd3);
    check_field("plan_walloc_evict", 128'(bus.evict_tag), 128'h1A2B3C);

    apply_stimulus("refill_no_we", 0, 1, 0, 0, 0, 24'h777777, 6'd4, 2'd0, '0, MEM_C);
    apply_stimulus("both_en_read", 0, 0, 1, 1, 0, 24'h000002, 6'd4, 2'd3, 32'h12345678, '0);
    apply_stimulus("both_en_write", 0, 0, 1, 1, 1, 24'h000002, 6'd4, 2'd3, 32'h12345678, '0);
    do_read("both_en_check", 24'h000002, 6'd4, 2'd3);

    apply_stimulus("rst_and_refill", 1, 1, 0, 1, 0, 24'hABCDE0, 6'd0, 2'd0, '0, MEM_A);
    do_read("after_rst", 24'hABCDE0, 6'd0, 2'd0);
    check_field("plan_after_rst_hit", 128'(bus.hit), 128'(0));
    do_reset("reset_again");
    do_refill("refill_no_miss", 24'h0F0F0F, 6'd5, 2'd1, 0, '0, MEM_C);
    do_read("refill_no_miss_rd", 24'h0F0F0F, 6'd5, 2'd1);

    $display("[TB] random phase");
    tags[0] = 24'h000001; tags[1] = 24'h000002; tags[2] = 24'hFFFFF0; tags[3] = 24'h5A5A5A;
    do_reset("rnd_reset");
    last_miss = 0;
    l_tag = '0; l_idx = '0; l_off = '0; l_rt = 0; l_din = '0;
    for (int i = 0; i < 300; i++) begin
      if (last_miss && ($urandom_range(0, 3) != 0)) begin
        do_refill("rnd_refill", l_tag, l_idx, $urandom_range(0, 3), l_rt, l_din,
                  {$urandom, $urandom, $urandom, $urandom});
        last_miss = 0;
      end else begin
        l_tag = tags[$urandom_range(0, 3)];
        l_idx = 6'($urandom_range(0, 2));
        l_off = 2'($urandom_range(0, 3));
        l_rt  = 1'($urandom_range(0, 1));
        l_din = $urandom;
        re = 1'($urandom_range(0, 1));
        we = !re || 1'($urandom_range(0, 1));
        apply_stimulus("rnd_lookup", 0, 0, re, we, l_rt, l_tag, l_idx, l_off, l_din, '0);
        last_miss = !m_hit;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_memory_sa.md
Name: cache_memory_sa

Overview:
- Parametrised N-way set-associative successor to the direct-mapped cache data/tag store.
- Holds tag, valid, dirty and block data per way, plus true-LRU state per set.
- Performs registered lookups, word writes on hit, and victim selection with dirty-block eviction on miss.
- Accepts a full-block refill from memory, with write-allocate merge.
- Sits between the cache controller FSM (which drives the enables and refill) and main memory.

Parameters:
- TAG_WIDTH, 24, tag field width.
- INDEX_WIDTH, 6, set index width; SETS = 2**INDEX_WIDTH.
- OFFSET_WIDTH, 2, word-in-block offset width; WORDS = 2**OFFSET_WIDTH.
- WORD_WIDTH, 32, data word width.
- WAYS, 2, associativity; power of 2, 1..8; WAYS=1 degenerates to direct-mapped.
- Derived: BLOCK_SIZE = WORDS*WORD_WIDTH (128); WAY_W = max(1, log2(WAYS)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- tag  in  TAG_WIDTH  request tag.
- index  in  INDEX_WIDTH  request set.
- blk_offset  in  OFFSET_WIDTH  word select within block.
- req_type  in  1  0 = read, 1 = write.
- read_en_cache  in  1  lookup strobe, read.
- write_en_cache  in  1  lookup strobe, write; when refill=1, qualifies the refill.
- refill  in  1  install data_in_mem into the latched victim way.
- data_in_mem  in  BLOCK_SIZE  block from memory.
- data_in  in  WORD_WIDTH  write data.
- dirty_block_out  out  BLOCK_SIZE  victim block data on miss.
- evict_tag  out  TAG_WIDTH  victim tag, for writeback address.
- victim_way  out  WAY_W  way chosen on last miss.
- hit  out  1  registered lookup result.
- data_out  out  WORD_WIDTH  registered read word.
- dirty_bit  out  1  victim valid AND dirty, i.e. writeback required.

Behaviour:
- Reset, synchronous:
  - All valid, dirty and data bits := 0.
  - LRU age of way w in every set := w.
  - All outputs := 0, including victim_way.
- Lookup (refill=0, read_en_cache|write_en_cache=1) has 1-cycle latency; outputs are valid after the next rising edge and hold until the next lookup or refill.
  - Way w matches when valid[w] AND tag_store[w]==tag. At most one way matches; the bench checks this.
  - Read hit: hit=1, data_out = matched block word[blk_offset], dirty_bit=0.
  - Write hit (req_type=1): word[blk_offset] := data_in, dirty := 1, hit=1. data_out is unchanged.
  - Any hit: matched way becomes MRU.
  - Miss: hit=0, data_out=0.
    - Victim = lowest-index invalid way; if all ways are valid, victim = the way with age WAYS-1.
    - victim_way is registered.
    - dirty_bit = valid & dirty of the victim.
    - dirty_block_out and evict_tag = victim data and tag.
    - Storage and LRU are not modified.
- Refill (refill=1 AND write_en_cache=1), single cycle, into set index and way victim_way:
  - Data := data_in_mem, tag := tag, valid := 1.
  - If req_type=1 (write-allocate): word[blk_offset] := data_in, dirty := 1. Otherwise dirty := 0.
  - Victim way becomes MRU.
  - hit := 1 on the following cycle; dirty_bit := 0.
  - data_out := installed word[blk_offset].
- LRU update on access to way a with old age k:
  - Age(a) := 0.
  - Every way with age < k increments.
  - Ages remain a permutation of 0..WAYS-1.
- Priority and corner cases:
  - rst over refill over lookup.
  - refill=1 with write_en_cache=0: no-op.
  - read_en and write_en both high: req_type decides the operation.
  - Refill after reset with no prior miss: targets way 0.
  - Reset mid-sequence discards the latched victim.
  - Same-set back-to-back lookups see the previous cycle's write (write-then-read ordering).

Test Plan:
- rst=1 one cycle, then read tag=0xABCDE0, idx=0 -> hit=0, dirty_bit=0, victim_way=0, data_out=0.
- Refill idx=0, tag=0xABCDE0, data_in_mem=0x11112222_33334444_55556666_77778888, req_type=0; then read offset 3 -> hit=1, data_out=0x11112222, dirty_bit=0.
- Write hit idx=0, offset 0, data_in=0xCAFEBABE; read offset 0 -> 0xCAFEBABE. Then miss with tag 0x000ABC, same set -> victim_way=1 (invalid way), dirty_bit=0.
- Refill way 1 with tag 0x000ABC. Touch tag 0xABCDE0 (way 0 now MRU). Then miss with tag 0x3C3C3C -> victim_way=1, dirty_bit=0, evict_tag=0x000ABC. Refill, then miss again with tag 0x111111 -> victim_way=0, dirty_bit=1, evict_tag=0xABCDE0, dirty_block_out offset 0 word = 0xCAFEBABE.
- Write miss idx=4, tag 0x1A2B3C, offset 2, data_in=0x4AFEBABE, then refill with req_type=1 -> stored word2=0x4AFEBABE, other words from memory; next lookup hit=1; evicting that line gives dirty_bit=1.
- Assert refill and rst together -> no install, valid cleared; following read -> hit=0.
